// File: rtl/utmi_rx_pkt_driver.sv
// rtl/utmi_rx_pkt_driver.sv - UTMI receive-side packet driver: frames a byte stream into RxActive/RxValid/RxError.
module utmi_rx_pkt_driver #(
    parameter int RXA_LEAD = 2,
    parameter int EOP_DLY  = 3,
    parameter int IPG_MIN  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  pkt_data_i,
    input  logic        pkt_valid_i,
    input  logic        pkt_last_i,
    input  logic        err_inject_i,
    output logic        pkt_ready_o,
    input  logic [3:0]  byte_gap_i,
    output logic [7:0]  DataIn_o,
    output logic        RxValid_o,
    output logic        RxActive_o,
    output logic        RxError_o,
    output logic        busy_o,
    output logic        pkt_done_o,
    output logic        pkt_err_o,
    output logic [10:0] byte_cnt_o
);

    localparam int CW = 16;
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] LEAD_LOAD = CW'(RXA_LEAD);
    localparam logic [CW-1:0] EOP_LOAD  = CW'(EOP_DLY);
    // The pkt_done cycle is itself the first low RxActive cycle of the gap.
    localparam logic [CW-1:0] IPG_LOAD  = CW'(IPG_MIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_DATA,
        S_GAP,
        S_EOP,
        S_IPG
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    assign pkt_ready_o = (state == S_DATA);
    assign busy_o      = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            cnt        <= CNT_ZERO;
            DataIn_o   <= 8'd0;
            RxValid_o  <= 1'b0;
            RxActive_o <= 1'b0;
            RxError_o  <= 1'b0;
            pkt_done_o <= 1'b0;
            pkt_err_o  <= 1'b0;
            byte_cnt_o <= 11'd0;
        end else begin
            RxValid_o  <= 1'b0;
            RxError_o  <= 1'b0;
            pkt_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pkt_valid_i) begin
                        state      <= S_LEAD;
                        cnt        <= LEAD_LOAD;
                        RxActive_o <= 1'b1;
                        byte_cnt_o <= 11'd0;
                        pkt_err_o  <= 1'b0;
                    end
                end
                S_LEAD: begin
                    if (cnt <= CNT_ONE) begin
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (pkt_valid_i) begin
                        DataIn_o  <= pkt_data_i;
                        RxValid_o <= 1'b1;
                        if (byte_cnt_o != 11'h7FF) begin
                            byte_cnt_o <= byte_cnt_o + 11'd1;
                        end
                        // Error injection outranks last and gap so the packet ends on the flagged byte.
                        if (err_inject_i) begin
                            RxError_o <= 1'b1;
                            pkt_err_o <= 1'b1;
                            state     <= S_EOP;
                            cnt       <= EOP_LOAD;
                        end else if (pkt_last_i) begin
                            state <= S_EOP;
                            cnt   <= EOP_LOAD;
                        end else if (byte_gap_i != 4'd0) begin
                            state <= S_GAP;
                            cnt   <= CW'(byte_gap_i);
                        end
                    end
                end
                S_GAP: begin
                    if (cnt <= CNT_ONE) begin
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_EOP: begin
                    if (cnt == CNT_ZERO) begin
                        RxActive_o <= 1'b0;
                        pkt_done_o <= 1'b1;
                        if (IPG_MIN > 1) begin
                            state <= S_IPG;
                            cnt   <= IPG_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_IPG: begin
                    if (cnt <= CNT_ONE) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_utmi_rx_pkt_driver.sv
// tb/tb_utmi_rx_pkt_driver.sv - scoreboard bench for utmi_rx_pkt_driver.
module tb_utmi_rx_pkt_driver;

    localparam int RXA_LEAD = 2;
    localparam int EOP_DLY  = 3;
    localparam int IPG_MIN  = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  pkt_data_i;
    logic        pkt_valid_i;
    logic        pkt_last_i;
    logic        err_inject_i;
    logic        pkt_ready_o;
    logic [3:0]  byte_gap_i;
    logic [7:0]  DataIn_o;
    logic        RxValid_o;
    logic        RxActive_o;
    logic        RxError_o;
    logic        busy_o;
    logic        pkt_done_o;
    logic        pkt_err_o;
    logic [10:0] byte_cnt_o;

    utmi_rx_pkt_driver #(
        .RXA_LEAD(RXA_LEAD),
        .EOP_DLY (EOP_DLY),
        .IPG_MIN (IPG_MIN)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pkt_data_i  (pkt_data_i),
        .pkt_valid_i (pkt_valid_i),
        .pkt_last_i  (pkt_last_i),
        .err_inject_i(err_inject_i),
        .pkt_ready_o (pkt_ready_o),
        .byte_gap_i  (byte_gap_i),
        .DataIn_o    (DataIn_o),
        .RxValid_o   (RxValid_o),
        .RxActive_o  (RxActive_o),
        .RxError_o   (RxError_o),
        .busy_o      (busy_o),
        .pkt_done_o  (pkt_done_o),
        .pkt_err_o   (pkt_err_o),
        .byte_cnt_o  (byte_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int nbytes;
        int cnt;
        int err;
    } pkt_t;

    pkt_t        exp_pkts[$];
    logic [8:0]  exp_bytes[$];
    int          rise_log[$];
    int          done_log[$];
    int          val_log[$];
    logic [7:0]  pk_data [0:2099];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          mon_bytes = 0;
    bit          act_prev = 1'b0;
    pkt_t        mp;
    logic [8:0]  mb;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    always @(posedge clk_i) cyc++;

    // Monitor: pops the expected byte on every RxValid and the expected packet on every pkt_done.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            act_prev  = 1'b0;
            mon_bytes = 0;
        end else begin
            if (RxActive_o && !act_prev) begin
                rise_log.push_back(cyc);
                mon_bytes = 0;
                chk("err_clear_at_start", pkt_err_o, 0);
                chk("cnt_clear_at_start", byte_cnt_o, 0);
            end
            if (RxValid_o || RxError_o) begin
                chk("valid_inside_active", RxActive_o, 1);
                chk("error_with_valid", RxValid_o, 1);
                if (exp_bytes.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", DataIn_o, cyc);
                end else begin
                    mb = exp_bytes.pop_front();
                    chk("rx_data", DataIn_o, mb[7:0]);
                    chk("rx_error", RxError_o, mb[8]);
                end
                val_log.push_back(cyc);
                mon_bytes++;
            end
            if (pkt_done_o) begin
                chk("done_rxactive_low", RxActive_o, 0);
                if (exp_pkts.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    mp = exp_pkts.pop_front();
                    chk("done_byte_cnt", byte_cnt_o, mp.cnt);
                    chk("done_pkt_err", pkt_err_o, mp.err);
                    chk("done_bytes_seen", mon_bytes, mp.nbytes);
                end
                done_log.push_back(cyc);
                done_count++;
            end
            act_prev = RxActive_o;
        end
    end

    task automatic clear_logs();
        rise_log.delete();
        done_log.delete();
        val_log.delete();
    endtask

    task automatic wait_accept();
        int  k;
        bit  got;
        k   = 0;
        got = 1'b0;
        while (!got && k < 300) begin
            @(negedge clk_i);
            if (pkt_ready_o) got = 1'b1;
            @(posedge clk_i);
            #1;
            k++;
        end
        if (!got) timeout_fail("accept_wait");
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_pkts.size() != 0 || busy_o) && k < 5000) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 5000) timeout_fail("idle_wait");
    endtask

    // Reference: the packet is truncated at the first injected error; count saturates at 2047.
    task automatic send_pkt(input int base, input int n, input int errpos, input int gap,
                            input int stall_at, input int stall_len);
        int   n_exp;
        bit   has_err;
        pkt_t p;
        has_err = (errpos >= 0 && errpos < n);
        n_exp   = has_err ? errpos + 1 : n;
        for (int i = 0; i < n_exp; i++) exp_bytes.push_back({(i == errpos), pk_data[base+i]});
        p.nbytes = n_exp;
        p.cnt    = (n_exp > 2047) ? 2047 : n_exp;
        p.err    = has_err ? 1 : 0;
        exp_pkts.push_back(p);
        for (int i = 0; i < n_exp; i++) begin
            if (i == stall_at && stall_len > 0) begin
                pkt_valid_i = 1'b0;
                repeat (stall_len) @(posedge clk_i);
                #1;
            end
            pkt_valid_i  = 1'b1;
            pkt_data_i   = pk_data[base+i];
            pkt_last_i   = (i == n - 1);
            err_inject_i = (i == errpos);
            byte_gap_i   = 4'(gap);
            wait_accept();
        end
        pkt_valid_i  = 1'b0;
        pkt_last_i   = 1'b0;
        err_inject_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n, ep, gp, sa, sl, k, dc;
        bit got;

        rst_i        = 1'b0;
        pkt_data_i   = 8'd0;
        pkt_valid_i  = 1'b0;
        pkt_last_i   = 1'b0;
        err_inject_i = 1'b0;
        byte_gap_i   = 4'd0;
        repeat (3) @(negedge clk_i);
        chk("rst_datain", DataIn_o, 0);
        chk("rst_rxvalid", RxValid_o, 0);
        chk("rst_rxactive", RxActive_o, 0);
        chk("rst_rxerror", RxError_o, 0);
        chk("rst_ready", pkt_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", pkt_done_o, 0);
        chk("rst_pkt_err", pkt_err_o, 0);
        chk("rst_byte_cnt", byte_cnt_o, 0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: back-to-back 3-byte packet
        pk_data[40] = 8'hA5; pk_data[41] = 8'hC3; pk_data[42] = 8'h3C;
        clear_logs();
        send_pkt(40, 3, -1, 0, -1, 0);
        wait_idle();
        chk("t1_first_valid", val_log[0] - rise_log[0], RXA_LEAD + 1);
        chk("t1_second_valid", val_log[1] - rise_log[0], RXA_LEAD + 2);
        chk("t1_third_valid", val_log[2] - rise_log[0], RXA_LEAD + 3);
        chk("t1_done", done_log[0] - rise_log[0], RXA_LEAD + 3 + EOP_DLY + 1);
        chk("t1_byte_cnt", byte_cnt_o, 3);

        // 2: same packet with a 2-cycle byte gap
        clear_logs();
        send_pkt(40, 3, -1, 2, -1, 0);
        wait_idle();
        chk("t2_rise_count", rise_log.size(), 1);
        chk("t2_gap_a", val_log[1] - val_log[0], 3);
        chk("t2_gap_b", val_log[2] - val_log[1], 3);
        chk("t2_eop", done_log[0] - val_log[2], EOP_DLY + 1);

        // 3: error injected on byte 2 of 4; remaining bytes must not be taken
        pk_data[0] = 8'h11; pk_data[1] = 8'h22; pk_data[2] = 8'h33; pk_data[3] = 8'h44;
        send_pkt(0, 4, 1, 0, -1, 0);
        pkt_valid_i = 1'b1;
        pkt_data_i  = pk_data[2];
        k   = 0;
        got = 1'b0;
        while (!got && k < 50) begin
            @(negedge clk_i);
            chk("t3_no_accept_after_err", pkt_ready_o, 0);
            if (pkt_done_o) got = 1'b1;
            k++;
        end
        pkt_valid_i = 1'b0;
        if (!got) timeout_fail("t3_done_wait");
        wait_idle();
        chk("t3_pkt_err_held", pkt_err_o, 1);
        chk("t3_byte_cnt", byte_cnt_o, 2);

        // 4: error packet followed immediately by a clean packet
        pk_data[10] = 8'h5A; pk_data[11] = 8'hF0;
        pk_data[20] = 8'h01; pk_data[21] = 8'h02; pk_data[22] = 8'h03;
        clear_logs();
        send_pkt(10, 2, 1, 0, -1, 0);
        send_pkt(20, 3, -1, 0, -1, 0);
        wait_idle();
        chk("t4_rise_count", rise_log.size(), 2);
        if (rise_log.size() == 2 && done_log.size() >= 1)
            chk("t4_ipg", rise_log[1] - done_log[0], IPG_MIN);
        chk("t4_pkt_err_final", pkt_err_o, 0);

        // 5: underrun of 5 cycles before byte 3
        pk_data[30] = 8'h9C; pk_data[31] = 8'h7E; pk_data[32] = 8'h81; pk_data[33] = 8'h66;
        clear_logs();
        send_pkt(30, 4, -1, 0, 2, 5);
        wait_idle();
        chk("t5_rise_count", rise_log.size(), 1);
        chk("t5_valid_count", val_log.size(), 4);
        chk("t5_pre_stall", val_log[1] - val_log[0], 1);
        chk("t5_stall", val_log[2] - val_log[1], 6);

        // 6: asynchronous reset during DATA
        exp_bytes.push_back({1'b0, 8'h77});
        pkt_valid_i  = 1'b1;
        pkt_data_i   = 8'h77;
        pkt_last_i   = 1'b0;
        err_inject_i = 1'b0;
        byte_gap_i   = 4'd0;
        wait_accept();
        pkt_valid_i = 1'b0;
        @(negedge clk_i);
        dc = done_count;
        #2 rst_i = 1'b0;
        #1;
        chk("t6_rxactive", RxActive_o, 0);
        chk("t6_rxvalid", RxValid_o, 0);
        chk("t6_datain", DataIn_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_byte_cnt", byte_cnt_o, 0);
        chk("t6_ready", pkt_ready_o, 0);
        repeat (4) @(negedge clk_i);
        chk("t6_no_done", done_count, dc);
        chk("t6_exp_bytes_drained", exp_bytes.size(), 0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        pk_data[50] = 8'hE7;
        send_pkt(50, 1, -1, 0, -1, 0);
        wait_idle();
        chk("t6_after_reset_cnt", byte_cnt_o, 1);

        // Randomised packets
        for (int p = 0; p < 40; p++) begin
            n  = $urandom_range(1, 8);
            ep = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            gp = $urandom_range(0, 3);
            sa = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
            sl = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) pk_data[100+i] = 8'($urandom);
            send_pkt(100, n, ep, gp, sa, sl);
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            #1;
        end
        wait_idle();

        // Byte counter saturation
        for (int i = 0; i < 2050; i++) pk_data[i] = 8'(i * 7);
        send_pkt(0, 2050, -1, 0, -1, 0);
        wait_idle();
        chk("sat_byte_cnt", byte_cnt_o, 2047);

        chk("final_bytes_left", exp_bytes.size(), 0);
        chk("final_pkts_left", exp_pkts.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
